// File: rtl/ad_ddr_pkg.sv
// Shared constants for the ADC-to-DDR write path: DDR port widths, scheduler
// state encodings and the ring-address step helper.
package ad_ddr_pkg;

  localparam int DDR_ADDR_W = 25;
  localparam int DDR_LEN_W  = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  // Advance a burst start address by one burst, wrapping past the last legal start.
  function automatic logic [DDR_ADDR_W-1:0] ring_next(
    input logic [DDR_ADDR_W-1:0] addr,
    input logic [DDR_ADDR_W-1:0] step,
    input logic [DDR_ADDR_W-1:0] base,
    input logic [DDR_ADDR_W-1:0] last
  );
    logic [DDR_ADDR_W:0] sum;
    sum = {1'b0, addr} + {1'b0, step};
    if (sum > {1'b0, last}) return base;
    return sum[DDR_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ad_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on o_data whenever
// the FIFO is non-empty, and a full FIFO still accepts a push alongside a pop.
module ad_sync_fifo #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_push_ok,
  output logic          o_pop_ok
);

  localparam logic [AW:0] L_DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   w_level;

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign o_level   = w_level;
  assign o_full    = (w_level == L_DEPTH);
  assign o_empty   = (w_level == '0);
  assign o_pop_ok  = i_pop && !o_empty;
  assign o_push_ok = i_push && (!o_full || o_pop_ok);
  // Forcing zero when empty keeps the data output at its reset value.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (o_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (o_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ad_ddr_wr_scheduler.sv
// Packs 16-bit ADC samples into 32-bit words, buffers them, and issues
// fixed-length DDR write bursts at ring-buffer addresses.
module ad_ddr_wr_scheduler
  import ad_ddr_pkg::*;
#(
  parameter int                    BURST_LEN = 5,
  parameter int                    FIFO_AW   = 6,
  parameter logic [DDR_ADDR_W-1:0] ADDR_BASE = 25'd0,
  parameter logic [DDR_ADDR_W-1:0] ADDR_LAST = 25'd30
) (
  input  logic                  phy_clk,
  input  logic                  reset,
  input  logic                  local_init_done,
  input  logic                  capture_en,
  input  logic                  ad_valid,
  input  logic [15:0]           ad_data,
  input  logic                  ovf_clr,
  output logic                  wr_burst_req,
  output logic [DDR_LEN_W-1:0]  wr_burst_len,
  output logic [DDR_ADDR_W-1:0] wr_burst_addr,
  input  logic                  wr_burst_data_req,
  input  logic                  wr_burst_data_rfifo,
  output logic [31:0]           wr_burst_data,
  input  logic                  wr_burst_finish,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  overflow,
  output logic [31:0]           words_written
);

  localparam logic [FIFO_AW:0]     L_BURST_LVL  = (FIFO_AW+1)'(BURST_LEN);
  localparam logic [DDR_ADDR_W-1:0] L_ADDR_STEP = DDR_ADDR_W'(BURST_LEN);

  logic [1:0]            r_state;
  logic                  r_req;
  logic [DDR_ADDR_W-1:0] r_addr;
  logic                  r_half_valid;
  logic [15:0]           r_half_data;
  logic                  r_ovf;
  logic [31:0]           r_words;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop_req;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_full;
  logic                  w_empty;
  logic [FIFO_AW:0]      w_level;
  logic [31:0]           w_fifo_data;

  assign w_accept  = capture_en && ad_valid;
  assign w_push    = w_accept && r_half_valid;
  assign w_pop_req = (r_state == S_DATA) && wr_burst_data_rfifo;

  ad_sync_fifo #(
    .DW (32),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (phy_clk),
    .rst       (reset),
    .i_push    (w_push),
    .i_data    ({ad_data, r_half_data}),
    .i_pop     (w_pop_req),
    .o_data    (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok)
  );

  // Packer: a held half word survives capture_en gaps until the next accepted sample.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      r_half_valid <= 1'b0;
      r_half_data  <= '0;
    end else if (w_accept) begin
      r_half_valid <= !r_half_valid;
      if (!r_half_valid) r_half_data <= ad_data;
    end
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      r_ovf   <= 1'b0;
      r_words <= '0;
    end else begin
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      else if (ovf_clr)         r_ovf <= 1'b0;
      if (w_pop_ok) r_words <= r_words + 32'd1;
    end
  end

  // Requests only start with a full burst buffered, so S_DATA never starves.
  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= ADDR_BASE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (local_init_done && (w_level >= L_BURST_LVL)) begin
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (wr_burst_data_req) begin
            r_req   <= 1'b0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (wr_burst_finish) begin
            r_state <= S_IDLE;
            r_addr  <= ring_next(r_addr, L_ADDR_STEP, ADDR_BASE, ADDR_LAST);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign wr_burst_req  = r_req;
  assign wr_burst_len  = DDR_LEN_W'(BURST_LEN);
  assign wr_burst_addr = r_addr;
  assign wr_burst_data = w_fifo_data;
  assign fifo_level    = w_level;
  assign overflow      = r_ovf;
  assign words_written = r_words;

endmodule

// File: tb/tb_ad_ddr_wr_scheduler.sv
// Directed bench for ad_ddr_wr_scheduler with a packed-word scoreboard and a
// simple ddr_ctrl write-port responder.
module tb_ad_ddr_wr_scheduler;

  logic        phy_clk = 1'b0;
  logic        reset = 1'b1;
  logic        local_init_done = 1'b0;
  logic        capture_en = 1'b0;
  logic        ad_valid = 1'b0;
  logic [15:0] ad_data = '0;
  logic        ovf_clr = 1'b0;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [24:0] wr_burst_addr;
  logic        wr_burst_data_req = 1'b0;
  logic        wr_burst_data_rfifo = 1'b0;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish = 1'b0;
  logic [6:0]  fifo_level;
  logic        overflow;
  logic [31:0] words_written;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic        half_m = 1'b0;
  logic [15:0] half_d = '0;
  logic        ovf_m = 1'b0;
  logic [31:0] ww_m = '0;

  always #5 phy_clk = ~phy_clk;

  ad_ddr_wr_scheduler dut (
    .phy_clk             (phy_clk),
    .reset               (reset),
    .local_init_done     (local_init_done),
    .capture_en          (capture_en),
    .ad_valid            (ad_valid),
    .ad_data             (ad_data),
    .ovf_clr             (ovf_clr),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data_rfifo (wr_burst_data_rfifo),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish),
    .fifo_level          (fifo_level),
    .overflow            (overflow),
    .words_written       (words_written)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge phy_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(wr_burst_req), 32'd0);
    check({tag, "_len"},   32'(wr_burst_len), 32'd5);
    check({tag, "_addr"},  32'(wr_burst_addr), 32'd0);
    check({tag, "_data"},  wr_burst_data, 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
    check({tag, "_words"}, words_written, 32'd0);
  endtask

  task automatic clear_model();
    q.delete();
    half_m = 1'b0;
    ovf_m  = 1'b0;
    ww_m   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  // One sample; the scoreboard mirrors packing and drop-on-full.
  task automatic send(input logic [15:0] d, input logic cap);
    capture_en = cap;
    ad_valid   = 1'b1;
    ad_data    = d;
    if (cap) begin
      if (!half_m) begin
        half_m = 1'b1;
        half_d = d;
      end else begin
        half_m = 1'b0;
        if (q.size() < 64) q.push_back({d, half_d});
        else ovf_m = 1'b1;
      end
    end
    tick();
    ad_valid = 1'b0;
    $display("sample %h cap=%0d level=%0d", d, cap, fifo_level);
    check("level", 32'(fifo_level), 32'(q.size()));
    check("ovf", 32'(overflow), 32'(ovf_m));
  endtask

  // Plays ddr_ctrl: accept the request, pop npop words, optionally finish on the last pop.
  task automatic burst(input logic [24:0] exp_addr, input int npop, input bit fin);
    int t = 0;
    logic [31:0] exp;
    while (wr_burst_req !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check("req_seen", 32'(wr_burst_req), 32'd1);
    check("addr", 32'(wr_burst_addr), 32'(exp_addr));
    wr_burst_data_req = 1'b1;
    tick();
    wr_burst_data_req = 1'b0;
    check("req_drop", 32'(wr_burst_req), 32'd0);
    for (int i = 0; i < npop; i++) begin
      exp = 32'hDEADBEEF;
      if (q.size() > 0) exp = q.pop_front();
      $display("burst addr=%0d word %0d data=%h", wr_burst_addr, i, wr_burst_data);
      check("data", wr_burst_data, exp);
      check("addr_hold", 32'(wr_burst_addr), 32'(exp_addr));
      wr_burst_data_rfifo = 1'b1;
      if (fin && i == npop - 1) wr_burst_finish = 1'b1;
      tick();
      wr_burst_data_rfifo = 1'b0;
      wr_burst_finish = 1'b0;
      ww_m = ww_m + 32'd1;
    end
    check("words", words_written, ww_m);
  endtask

  initial begin
    // Power-on reset
    tick();
    check_reset_outputs("por");
    reset = 1'b0;
    local_init_done = 1'b1;

    // Test 1: reset mid S_DATA after two pops
    for (int i = 1; i <= 10; i++) send(16'(i), 1'b1);
    burst(25'd0, 2, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midrst");
    tick();
    reset = 1'b0;
    clear_model();

    // Test 2: ten samples, one burst at address 0
    for (int i = 1; i <= 10; i++) send(16'(i), 1'b1);
    check("head_t2", wr_burst_data, 32'h00020001);
    burst(25'd0, 5, 1'b1);
    check("addr_t2", 32'(wr_burst_addr), 32'd5);

    // Test 3: seven back-to-back bursts wrap the ring
    do_reset();
    for (int i = 0; i < 70; i++) send(16'(16'h0100 + i), 1'b1);
    for (int b = 0; b < 7; b++) burst(25'(b * 5), 5, 1'b1);
    check("addr_wrap", 32'(wr_burst_addr), 32'd0);
    check("words35", words_written, 32'd35);

    // Test 4: request held off while the FIFO fills and overflows
    do_reset();
    for (int i = 0; i < 10; i++) send(16'(16'h4000 + i), 1'b1);
    tick();
    check("req_wait", 32'(wr_burst_req), 32'd1);
    for (int i = 10; i < 128; i++) send(16'(16'h4000 + i), 1'b1);
    check("req_hold", 32'(wr_burst_req), 32'd1);
    check("addr_stable", 32'(wr_burst_addr), 32'd0);
    check("level_full", 32'(fifo_level), 32'd64);
    send(16'hAAAA, 1'b1);
    send(16'hBBBB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_sticky", 32'(overflow), 32'd1);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_m = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    burst(25'd0, 5, 1'b1);

    // Test 5: no request while calibration is pending
    do_reset();
    local_init_done = 1'b0;
    for (int i = 0; i < 24; i++) send(16'(16'h5000 + i), 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_req_init", 32'(wr_burst_req), 32'd0);
    end
    local_init_done = 1'b1;
    tick();
    check("req_after_init", 32'(wr_burst_req), 32'd1);
    burst(25'd0, 5, 1'b1);
    burst(25'd5, 5, 1'b1);

    // Test 6: half word held across a long capture_en gap
    do_reset();
    send(16'h1111, 1'b1);
    for (int i = 0; i < 50; i++) send(16'($urandom_range(0, 65535)), 1'b0);
    send(16'h2222, 1'b1);
    check("gap_level", 32'(fifo_level), 32'd1);
    check("gap_word", wr_burst_data, 32'h22221111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
